// File: rtl/inst_mem_prog.sv
// Host-programmable instruction memory with a registered 1-cycle fetch port,
// halt-word detection and out-of-range reporting. Define INST_MEM_PARITY_EN for per-word parity.
module inst_mem_prog #(
    parameter int unsigned A         = 10,
    parameter int unsigned W         = 9,
    parameter int unsigned DEPTH     = 2**A,
    parameter logic [W-1:0] HALT_WORD = '1,
    parameter logic [W-1:0] NOP_WORD  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         prog_we,
    input  logic [A-1:0] prog_addr,
    input  logic [W-1:0] prog_data,
    input  logic         fetch_req,
    input  logic         stall,
    input  logic [A-1:0] inst_address,
    output logic [W-1:0] inst_out,
    output logic         inst_valid,
    output logic         addr_err,
`ifdef INST_MEM_PARITY_EN
    output logic         parity_err,
`endif
    output logic         done,
    output logic [A:0]   prog_count
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0]  DEPTH_W = (A+1)'(DEPTH);
    localparam logic [A:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_word;
    logic         wr_in_range, rd_in_range, wr_en;

    logic [W-1:0] inst_out_d;
    logic         inst_valid_d, addr_err_d, done_d;
    logic [A:0]   prog_count_d;

    assign wr_in_range = {1'b0, prog_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, inst_address} < DEPTH_W;
    assign wr_en       = (state_q == ST_LOAD) && prog_we && wr_in_range && !rst;
    assign rd_word     = mem[inst_address[AW-1:0]];

    // Storage is deliberately unreset; the rst gate drops a write coinciding with reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[prog_addr[AW-1:0]] <= prog_data;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic mem_par [DEPTH];
    logic rd_par_bad;
    logic parity_err_d;

    assign rd_par_bad = (^rd_word) != mem_par[inst_address[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_par[prog_addr[AW-1:0]] <= ^prog_data;
        end
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        inst_out_d   = inst_out;
        inst_valid_d = inst_valid;
        addr_err_d   = addr_err;
        done_d       = done;
        prog_count_d = prog_count;
`ifdef INST_MEM_PARITY_EN
        parity_err_d = parity_err;
`endif
        case (state_q)
            ST_LOAD: begin
                inst_valid_d = 1'b0;
                done_d       = 1'b0;
                if (!start) begin
                    state_d = ST_RUN;
                end
                if (wr_en && (prog_count != CNT_MAX)) begin
                    prog_count_d = prog_count + (A+1)'(1);
                end
            end
            ST_RUN: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    inst_valid_d = 1'b0;
                    done_d       = 1'b0;
                    prog_count_d = '0;
                end else if (!stall) begin
                    if (fetch_req) begin
                        inst_valid_d = 1'b1;
                        if (rd_in_range) begin
                            inst_out_d = rd_word;
                            addr_err_d = 1'b0;
`ifdef INST_MEM_PARITY_EN
                            parity_err_d = rd_par_bad;
`endif
                            if (rd_word == HALT_WORD) begin
                                state_d = ST_HALTED;
                                done_d  = 1'b1;
                            end
                        end else begin
                            inst_out_d = NOP_WORD;
                            addr_err_d = 1'b1;
`ifdef INST_MEM_PARITY_EN
                            parity_err_d = 1'b0;
`endif
                        end
                    end else begin
                        inst_valid_d = 1'b0;
                    end
                end
            end
            ST_HALTED: begin
                inst_valid_d = 1'b0;
                done_d       = 1'b1;
                if (start) begin
                    state_d      = ST_LOAD;
                    done_d       = 1'b0;
                    prog_count_d = '0;
                end
            end
            default: begin
                state_d      = ST_LOAD;
                inst_valid_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            inst_out   <= NOP_WORD;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
            done       <= 1'b0;
            prog_count <= '0;
`ifdef INST_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            inst_out   <= inst_out_d;
            inst_valid <= inst_valid_d;
            addr_err   <= addr_err_d;
            done       <= done_d;
            prog_count <= prog_count_d;
`ifdef INST_MEM_PARITY_EN
            parity_err <= parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_inst_mem_prog.sv
// Directed bench for inst_mem_prog (A=10, W=9, DEPTH=512).
module tb_inst_mem_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [8:0]  prog_data;
    logic        fetch_req;
    logic        stall;
    logic [9:0]  inst_address;
    logic [8:0]  inst_out;
    logic        inst_valid;
    logic        addr_err;
    logic        done;
    logic [10:0] prog_count;
`ifdef INST_MEM_PARITY_EN
    logic        parity_err;
`endif

    int tests = 0;
    int fails = 0;

    inst_mem_prog #(.A(10), .W(9), .DEPTH(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .fetch_req    (fetch_req),
        .stall        (stall),
        .inst_address (inst_address),
        .inst_out     (inst_out),
        .inst_valid   (inst_valid),
        .addr_err     (addr_err),
`ifdef INST_MEM_PARITY_EN
        .parity_err   (parity_err),
`endif
        .done         (done),
        .prog_count   (prog_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] a, input logic [8:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Fetch one address and compare the registered result.
    task automatic fetch_check(input string name, input logic [9:0] a,
                               input logic [8:0] exp_out, input logic exp_err);
        fetch_req    = 1'b1;
        inst_address = a;
        tick();
        fetch_req    = 1'b0;
        tests++;
        if ({inst_out, inst_valid, addr_err} !== {exp_out, 1'b1, exp_err}) begin
            fails++;
            $display("FAIL %s: out=%h valid=%b err=%b, expected out=%h valid=1 err=%b",
                     name, inst_out, inst_valid, addr_err, exp_out, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        fetch_req = 1'b0; stall = 1'b0; inst_address = '0;
        tick();
        tick();
        tests++;
        if ({inst_out, inst_valid, addr_err, done, prog_count} !== '0) begin
            fails++;
            $display("FAIL reset: out=%h valid=%b err=%b done=%b cnt=%0d, expected all 0",
                     inst_out, inst_valid, addr_err, done, prog_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_run();
        write_word(10'd0,   9'h011);
        write_word(10'd1,   9'h022);
        write_word(10'd2,   9'h033);
        write_word(10'd3,   9'h1FF);
        write_word(10'd5,   9'h055);
        write_word(10'd6,   9'h066);
        write_word(10'd511, 9'h1A5);
        tests++;
        if (prog_count !== 11'd7 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL load_count: cnt=%0d valid=%b, expected cnt=7 valid=0", prog_count, inst_valid);
        end
        write_word(10'd600, 9'h0BB);
        tests++;
        if (prog_count !== 11'd7) begin
            fails++;
            $display("FAIL oor_write_count: cnt=%0d, expected 7", prog_count);
        end
        start = 1'b0;
        tick();
        fetch_check("fetch0", 10'd0, 9'h011, 1'b0);
        fetch_check("fetch1", 10'd1, 9'h022, 1'b0);
        fetch_check("fetch2", 10'd2, 9'h033, 1'b0);
        fetch_req = 1'b1; inst_address = 10'd3;
        tick();
        tests++;
        if (inst_out !== 9'h1FF || inst_valid !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL halt_fetch: out=%h valid=%b done=%b, expected 1ff 1 1", inst_out, inst_valid, done);
        end
        inst_address = 10'd0;
        tick();
        fetch_req = 1'b0;
        tests++;
        if (inst_out !== 9'h1FF || inst_valid !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL halted_hold: out=%h valid=%b done=%b, expected 1ff 0 1", inst_out, inst_valid, done);
        end
    endtask

    task automatic enter_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        start = 1'b1;
        tick();
        tests++;
        if (done !== 1'b0 || prog_count !== 11'd0 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL reload_clear: done=%b cnt=%0d valid=%b, expected 0 0 0", done, prog_count, inst_valid);
        end
        start = 1'b0;
        tick();
        fetch_check("fetch5", 10'd5, 9'h055, 1'b0);
        stall = 1'b1; fetch_req = 1'b1; inst_address = 10'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (inst_out !== 9'h055 || inst_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold%0d: out=%h valid=%b, expected 055 1", i, inst_out, inst_valid);
            end
        end
        stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        tests++;
        if (inst_out !== 9'h066 || inst_valid !== 1'b1) begin
            fails++;
            $display("FAIL after_stall: out=%h valid=%b, expected 066 1", inst_out, inst_valid);
        end
        tick();
        tests++;
        if (inst_out !== 9'h066 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_drop: out=%h valid=%b, expected 066 0", inst_out, inst_valid);
        end
    endtask

    task automatic test_out_of_range();
        fetch_check("fetch600", 10'd600, 9'h000, 1'b1);
        fetch_check("fetch511", 10'd511, 9'h1A5, 1'b0);
        fetch_check("fetch512", 10'd512, 9'h000, 1'b1);
        fetch_check("fetch6",   10'd6,   9'h066, 1'b0);
    endtask

    task automatic test_run_write_ignored();
        prog_we = 1'b1; prog_addr = 10'd2; prog_data = 9'h0AA;
        tick();
        prog_we = 1'b0;
        tests++;
        if (prog_count !== 11'd0) begin
            fails++;
            $display("FAIL run_write_count: cnt=%0d, expected 0", prog_count);
        end
        fetch_check("run_write_mem2", 10'd2, 9'h033, 1'b0);
    endtask

    task automatic test_start_wins();
        start = 1'b1; fetch_req = 1'b1; inst_address = 10'd0;
        tick();
        fetch_req = 1'b0;
        tests++;
        if (inst_out !== 9'h033 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL start_wins: out=%h valid=%b, expected 033 0", inst_out, inst_valid);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_halt_with_stall();
        fetch_req = 1'b1; inst_address = 10'd3;
        tick();
        stall = 1'b1; inst_address = 10'd0;
        tick();
        stall = 1'b0; fetch_req = 1'b0;
        tests++;
        if (done !== 1'b1 || inst_out !== 9'h1FF || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_stall: done=%b out=%h valid=%b, expected 1 1ff 0", done, inst_out, inst_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        enter_run();
        fetch_check("pre_reset_fetch1", 10'd1, 9'h022, 1'b0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({inst_out, inst_valid, addr_err, done, prog_count} !== '0) begin
            fails++;
            $display("FAIL async_reset: out=%h valid=%b err=%b done=%b cnt=%0d, expected all 0",
                     inst_out, inst_valid, addr_err, done, prog_count);
        end
        start = 1'b1; prog_we = 1'b1; prog_addr = 10'd1; prog_data = 9'h0EE;
        tick();
        prog_we = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        tick();
        fetch_check("post_reset_fetch1", 10'd1, 9'h022, 1'b0);
    endtask

`ifdef INST_MEM_PARITY_EN
    task automatic test_parity();
        start = 1'b1;
        tick();
        write_word(10'd7, 9'h007);
        dut.mem_par[7] = ~dut.mem_par[7];
        start = 1'b0;
        tick();
        fetch_check("par_fetch7", 10'd7, 9'h007, 1'b0);
        tests++;
        if (parity_err !== 1'b1) begin
            fails++;
            $display("FAIL parity_bad: parity_err=%b, expected 1", parity_err);
        end
        fetch_check("par_fetch0", 10'd0, 9'h011, 1'b0);
        tests++;
        if (parity_err !== 1'b0) begin
            fails++;
            $display("FAIL parity_good: parity_err=%b, expected 0", parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_run();
        test_stall();
        test_out_of_range();
        test_run_write_ignored();
        test_start_wins();
        test_halt_with_stall();
        test_reset_mid_run();
`ifdef INST_MEM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_prog.md
Name: inst_mem_prog

Overview:
- Parametrised successor to the combinational instruction ROM: a synchronous, host-programmable instruction memory with a registered fetch port.
- Host writes the program word by word in LOAD mode; the fetch unit then reads with 1-cycle latency and a valid/stall handshake.
- Detects the halt word and out-of-range fetches, and reports completion to the top level.

Parameters:
- A, 10, instruction address width.
- W, 9, instruction word width.
- DEPTH, 2**A, number of implemented words; must be ≤ 2**A.
- HALT_WORD, all ones ('1), encoding that ends execution.
- NOP_WORD, 0, word returned for out-of-range fetches.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high; clears all control state and outputs.
- Start  in  1  1 = LOAD mode (host programs memory); falling edge begins RUN.
- ProgWe  in  1  host write strobe; honoured only in LOAD.
- ProgAddr  in  A  host write address.
- ProgData  in  W  host write data.
- FetchReq  in  1  fetch request for InstAddress; honoured only in RUN.
- Stall  in  1  hold current InstOut/InstValid; FetchReq ignored while high.
- InstAddress  in  A  fetch address.
- InstOut  out  W  registered instruction.
- InstValid  out  1  InstOut holds the result of an accepted fetch.
- AddrErr  out  1  last accepted fetch had InstAddress ≥ DEPTH.
- Done  out  1  halt word fetched; sticky until Reset or Start.
- ProgCount  out  A+1  number of accepted host writes since entering LOAD; saturates at 2**(A+1)-1.

Behaviour:
- Reset values:
  - State = LOAD.
  - InstOut = NOP_WORD; InstValid = 0; AddrErr = 0; Done = 0; ProgCount = 0.
  - Memory array is not reset; contents survive Reset.
- FSM states: LOAD, RUN, HALTED.
  - LOAD → RUN: on the cycle after Start is sampled 0.
  - RUN → HALTED: on the edge that registers InstOut == HALT_WORD.
  - RUN or HALTED → LOAD: whenever Start is sampled 1. Clears Done, InstValid and ProgCount.
- LOAD writes:
  - ProgWe = 1 writes mem[ProgAddr] = ProgData at the edge and increments ProgCount.
  - ProgAddr ≥ DEPTH: write dropped, ProgCount not incremented.
  - InstValid held 0 throughout LOAD.
- RUN fetch:
  - Accepted when FetchReq = 1 and Stall = 0.
  - Next edge: InstOut = mem[InstAddress], InstValid = 1, AddrErr = 0. Latency is exactly 1 cycle; back-to-back fetches give one word per cycle.
  - Out of range (InstAddress ≥ DEPTH): InstOut = NOP_WORD, AddrErr = 1, InstValid = 1.
  - FetchReq = 0 and Stall = 0: InstValid falls to 0; InstOut holds its value.
  - Stall = 1: InstOut, InstValid and AddrErr all hold.
- HALTED:
  - Done = 1; further FetchReq ignored; InstOut holds HALT_WORD; InstValid falls to 0 the cycle after entry.
  - ProgWe ignored in RUN and HALTED.
- Simultaneous events:
  - Start = 1 with FetchReq = 1: Start wins; no fetch occurs.
  - Halt word fetched while Stall rises the same cycle: the fetch was accepted before the stall, so HALTED is still entered.
- Reset mid-write: the write in flight at Reset assertion is discarded; memory is otherwise unchanged.
- Reset mid-fetch: outputs clear immediately, asynchronously.

Optional Feature:
- Macro INST_MEM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit, computed over ProgData on write.
  - An added output ParityErr (1 bit) is registered alongside InstOut. It is 1 when the parity of the fetched word mismatches its stored bit, follows the same hold rules as AddrErr, and resets to 0.
  - Out-of-range fetches give ParityErr = 0.
- When undefined: no parity storage, no ParityErr port; behaviour is otherwise identical.

Test Plan:
1. Reset, Start = 1; write mem[0..3] = 9'h011, 9'h022, 9'h033, 9'h1FF; Start = 0; fetch 0..3 back-to-back → InstOut = 011, 022, 033, 1FF on consecutive cycles, each one cycle after its request; Done = 1 after 1FF; ProgCount = 4.
2. RUN: fetch addr 5, Stall = 1 for 3 cycles with FetchReq = 1 and addr 6 → InstOut holds mem[5] and InstValid stays 1 for the 3 cycles; after Stall drops, mem[6] appears one cycle later.
3. DEPTH = 512, A = 10: fetch InstAddress = 600 → InstOut = 0, AddrErr = 1, InstValid = 1; host write to 600 in LOAD → dropped, ProgCount unchanged.
4. Assert ProgWe with ProgAddr = 2, ProgData = 9'h0AA during RUN → mem[2] unchanged, confirmed by a subsequent fetch of addr 2.
5. Assert Reset asynchronously mid-RUN between edges → all outputs 0 immediately, state LOAD; deassert Reset, Start = 0, fetch addr 1 → the value written before Reset is returned.
6. INST_MEM_PARITY_EN defined: write 9'h007, force the stored parity bit inverted, fetch → ParityErr = 1; fetch an untouched word → ParityErr = 0.
